// File: rtl/tracker_pkg.sv
// Shared constants, classification type and helpers for region_activity_tracker.
package tracker_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned COORD_W      = 10;
    localparam int unsigned STREAK_W     = 4;

    typedef enum logic [1:0] {
        CLS_OFF,
        CLS_ON,
        CLS_HOLD
    } cls_e;

    // Index width that stays legal for a single region
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/region_decoder.sv
// Maps a pixel column onto one of NUM_REGIONS equal-width vertical strips.
// Purely combinational; the last strip absorbs the division remainder.
module region_decoder
    import tracker_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = 4,
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    localparam int unsigned IDX_W      = idx_width(NUM_REGIONS)
) (
    input  logic [COORD_W-1:0] x,
    output logic [IDX_W-1:0]   idx,
    output logic               in_range
);

    localparam int unsigned RW = H_ACTIVE / NUM_REGIONS;

    // Comparator chain: the highest strip whose left edge is <= x wins
    always_comb begin
        idx = '0;
        for (int unsigned k = 1; k < NUM_REGIONS; k++) begin
            if (32'(x) >= k * RW) begin
                idx = IDX_W'(k);
            end
        end
    end

    assign in_range = (32'(x) < H_ACTIVE);

endmodule

// File: rtl/region_activity_tracker.sv
// Per-strip colour-hit counter with frame thresholding and cross-frame debounce.
// Optional hysteresis (ON/OFF thresholds with a HOLD band) is enabled by defining
// TRACKER_HYST_EN; without it every frame is classified strictly ON or OFF.
module region_activity_tracker
    import tracker_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = 4,
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned Y_MIN       = 0,
    parameter int unsigned Y_MAX       = 479,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned THRESH      = 200,
    parameter int unsigned THRESH_OFF  = 100,
    parameter int unsigned DEB_FRAMES  = 3,
    localparam int unsigned SEL_W      = idx_width(NUM_REGIONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_valid,
    input  logic [COORD_W-1:0]     pix_x,
    input  logic [COORD_W-1:0]     pix_y,
    input  logic                   pix_hit,
    input  logic                   frame_start,
    input  logic                   frame_end,
    output logic [NUM_REGIONS-1:0] region_detected,
    output logic                   det_valid,
    input  logic [SEL_W-1:0]       cnt_sel,
    output logic [CNT_W-1:0]       cnt_out
);

    localparam logic [STREAK_W-1:0] DEB = STREAK_W'(DEB_FRAMES);

    if (THRESH_OFF >= THRESH) begin : g_bad_thresh
        $error("THRESH_OFF must be below THRESH");
    end

    logic               v1_q, h1_q, fs1_q, fe1_q;
    logic [COORD_W-1:0] x1_q, y1_q;
    logic               hit2_q, fs2_q, fe2_q;
    logic [SEL_W-1:0]   idx2_q;
    logic [SEL_W-1:0]   idx1;
    logic               x_in_range;
    logic               y_in_window;
    logic [CNT_W-1:0]   latch_all [NUM_REGIONS];

    region_decoder #(
        .NUM_REGIONS(NUM_REGIONS),
        .H_ACTIVE   (H_ACTIVE)
    ) u_decoder (
        .x       (x1_q),
        .idx     (idx1),
        .in_range(x_in_range)
    );

    // +1 form keeps the lower bound meaningful when Y_MIN is 0
    assign y_in_window = (32'(y1_q) + 32'd1 > Y_MIN) && (32'(y1_q) <= Y_MAX);

    // S1 input register, S2 decode register, close strobe and count readback
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            h1_q      <= 1'b0;
            fs1_q     <= 1'b0;
            fe1_q     <= 1'b0;
            x1_q      <= '0;
            y1_q      <= '0;
            hit2_q    <= 1'b0;
            fs2_q     <= 1'b0;
            fe2_q     <= 1'b0;
            idx2_q    <= '0;
            det_valid <= 1'b0;
            cnt_out   <= '0;
        end else begin
            v1_q      <= pix_valid;
            h1_q      <= pix_hit;
            fs1_q     <= frame_start;
            fe1_q     <= frame_end;
            x1_q      <= pix_x;
            y1_q      <= pix_y;
            hit2_q    <= v1_q && h1_q && x_in_range && y_in_window;
            idx2_q    <= idx1;
            fs2_q     <= fs1_q;
            fe2_q     <= fe1_q;
            det_valid <= fe2_q;
            cnt_out   <= (32'(cnt_sel) < NUM_REGIONS) ? latch_all[cnt_sel] : '0;
        end
    end

    for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_region
        logic [CNT_W-1:0]    acc_q, latch_q, acc_inc;
        logic [STREAK_W-1:0] on_q, off_q, on_nx, off_nx;
        logic                det_q, det_nx, bump;
        cls_e                cls;

        assign bump    = hit2_q && (idx2_q == SEL_W'(k)) && (acc_q != '1);
        assign acc_inc = acc_q + CNT_W'(bump);

        // Classify the closing frame's count, including this cycle's pixel
        always_comb begin
            cls = CLS_OFF;
            if (32'(acc_inc) >= THRESH) begin
                cls = CLS_ON;
            end
`ifdef TRACKER_HYST_EN
            else if (32'(acc_inc) >= THRESH_OFF) begin
                cls = CLS_HOLD;
            end
`endif
        end

        // Saturating streaks; output flips only when a streak reaches DEB_FRAMES
        always_comb begin
            on_nx  = on_q;
            off_nx = off_q;
            unique case (cls)
                CLS_ON: begin
                    on_nx  = (on_q == DEB) ? on_q : on_q + 1'b1;
                    off_nx = '0;
                end
                CLS_OFF: begin
                    off_nx = (off_q == DEB) ? off_q : off_q + 1'b1;
                    on_nx  = '0;
                end
                default: ;
            endcase
            det_nx = det_q;
            if (on_nx == DEB) begin
                det_nx = 1'b1;
            end else if (off_nx == DEB) begin
                det_nx = 1'b0;
            end
        end

        // Accumulate, close the frame on aligned frame_end, resync on frame_start
        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q   <= '0;
                latch_q <= '0;
                on_q    <= '0;
                off_q   <= '0;
                det_q   <= 1'b0;
            end else if (fe2_q) begin
                latch_q <= acc_inc;
                acc_q   <= '0;
                on_q    <= on_nx;
                off_q   <= off_nx;
                det_q   <= det_nx;
            end else if (fs2_q) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_inc;
            end
        end

        assign latch_all[k]       = latch_q;
        assign region_detected[k] = det_q;
    end

endmodule

// File: tb/tb_region_activity_tracker.sv
// Self-checking bench for region_activity_tracker: a 4-strip/16-bit instance and a
// 3-strip/8-bit instance share stimulus and are compared against a frame-level model.
module tb_region_activity_tracker;

    logic       clk = 1'b0;
    logic       rst, pix_valid, pix_hit, frame_start, frame_end;
    logic [9:0] pix_x, pix_y;
    logic [1:0] cnt_sel;
    logic [3:0] det_a;
    logic       dv_a;
    logic [15:0] cnt_a;
    logic [2:0] det_b;
    logic       dv_b;
    logic [7:0] cnt_b;

    int checks   = 0;
    int failures = 0;

    // Model state, [instance][strip]
    int cnt_m   [2][4];
    int latch_m [2][4];
    bit det_m   [2][4];
    int hist_m  [2][4];
    int hlen_m  [2][4];

    always #5 clk = ~clk;

    region_activity_tracker u_dut_a (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_hit(pix_hit), .frame_start(frame_start), .frame_end(frame_end),
        .region_detected(det_a), .det_valid(dv_a), .cnt_sel(cnt_sel), .cnt_out(cnt_a)
    );

    region_activity_tracker #(
        .NUM_REGIONS(3),
        .CNT_W      (8)
    ) u_dut_b (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_hit(pix_hit), .frame_start(frame_start), .frame_end(frame_end),
        .region_detected(det_b), .det_valid(dv_b), .cnt_sel(cnt_sel), .cnt_out(cnt_b)
    );

    function automatic int nr(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic int cmax(input int i);
        return (i == 0) ? 65535 : 255;
    endfunction

    function automatic int strip_of(input int i, input int x);
        int r;
        r = x / (640 / nr(i));
        return (r > nr(i) - 1) ? nr(i) - 1 : r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 4; r++) begin
                cnt_m[i][r] = 0; latch_m[i][r] = 0; det_m[i][r] = 0;
                hist_m[i][r] = 0; hlen_m[i][r] = 0;
            end
        end
    endtask

    task automatic model_pixel(input int x, input int y);
        if (x < 640 && y <= 479) begin
            for (int i = 0; i < 2; i++) begin
                if (cnt_m[i][strip_of(i, x)] < cmax(i)) cnt_m[i][strip_of(i, x)]++;
            end
        end
    endtask

    // A strip turns on/off once its last three non-HOLD frames all agree
    task automatic model_close();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < nr(i); r++) begin
                int  c;
                bit  is_on, is_off;
                c = cnt_m[i][r];
                latch_m[i][r] = c;
                cnt_m[i][r] = 0;
                is_on = (c >= 200);
`ifdef TRACKER_HYST_EN
                is_off = (c < 100);
`else
                is_off = !is_on;
`endif
                if (is_on || is_off) begin
                    hist_m[i][r] = (hist_m[i][r] << 1) | int'(is_on);
                    hlen_m[i][r]++;
                end
                if (hlen_m[i][r] >= 3) begin
                    if ((hist_m[i][r] & 7) == 7) det_m[i][r] = 1'b1;
                    else if ((hist_m[i][r] & 7) == 0) det_m[i][r] = 1'b0;
                end
            end
        end
    endtask

    task automatic cyc(input bit v, input int x, input int y, input bit h,
                       input bit fs, input bit fe);
        pix_valid = v; pix_x = 10'(x); pix_y = 10'(y); pix_hit = h;
        frame_start = fs; frame_end = fe;
        if (fs) begin
            for (int i = 0; i < 2; i++) for (int r = 0; r < 4; r++) cnt_m[i][r] = 0;
        end
        if (v && h && !fs) model_pixel(x, y);
        @(posedge clk);
        #1;
        pix_valid = 1'b0; pix_hit = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    endtask

    task automatic hits(input int n, input int x, input int y);
        repeat (n) cyc(1'b1, x, y, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic close_frame(input bit with_pix, input int x, input string tag);
        logic [3:0] ea;
        logic [2:0] eb;
        cyc(with_pix, x, 100, with_pix, 1'b0, 1'b1);
        model_close();
        for (int r = 0; r < 4; r++) ea[r] = det_m[0][r];
        for (int r = 0; r < 3; r++) eb[r] = det_m[1][r];
        cyc(0, 0, 0, 0, 0, 0);
        check({tag, "_dv_early_a"}, dv_a, 0);
        check({tag, "_dv_early_b"}, dv_b, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check({tag, "_dv_a"}, dv_a, 1);
        check({tag, "_dv_b"}, dv_b, 1);
        check({tag, "_det_a"}, det_a, ea);
        check({tag, "_det_b"}, det_b, eb);
        cyc(0, 0, 0, 0, 0, 0);
        check({tag, "_dv_pulse_a"}, dv_a, 0);
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            cyc(0, 0, 0, 0, 0, 0);
            check($sformatf("%s_cnt_a%0d", tag, s), cnt_a, latch_m[0][s]);
            check($sformatf("%s_cnt_b%0d", tag, s), cnt_b, (s < 3) ? latch_m[1][s] : 0);
        end
    endtask

    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_hit = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
        pix_x = '0; pix_y = '0; cnt_sel = '0;
        model_reset();
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        check("reset_det_a", det_a, 0);
        check("reset_dv_a", dv_a, 0);
        check("reset_cnt_a", cnt_a, 0);
        check("reset_det_b", det_b, 0);
        check("reset_cnt_b", cnt_b, 0);

        // Reset mid-frame discards the partial frame
        hits(300, 10, 50);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        close_frame(0, 0, "t1");

        // Debounce: output rises only after the third qualifying frame
        for (int f = 0; f < 3; f++) begin
            hits(250, 10, 50);
            close_frame(0, 0, $sformatf("t2_f%0d", f));
        end
        check("t2_final_det", det_a, 4'b0001);

        // Strip edges
        hits(5, 159, 10);
        hits(7, 160, 10);
        hits(9, 639, 10);
        hits(4, 638, 479);
        hits(6, 640, 10);
        close_frame(0, 0, "t3");

        // Pixel coincident with frame_end, 8-bit saturation, then an empty frame
        hits(300, 10, 20);
        close_frame(1, 10, "t4");
        close_frame(0, 0, "t4_empty");

        // Hysteresis band on strip 1
        for (int f = 0; f < 3; f++) begin
            hits(250, 200, 60);
            close_frame(0, 0, $sformatf("t5_on%0d", f));
        end
        for (int f = 0; f < 3; f++) begin
            hits(150, 200, 60);
            close_frame(0, 0, $sformatf("t5_mid%0d", f));
        end
        for (int f = 0; f < 3; f++) begin
            hits(50, 200, 60);
            close_frame(0, 0, $sformatf("t5_low%0d", f));
        end

        // frame_start resync and out-of-window lines
        hits(120, 30, 40);
        cyc(0, 0, 0, 0, 1, 0);
        hits(90, 30, 40);
        hits(20, 30, 480);
        close_frame(0, 0, "t6");

        // Randomized frames biased toward one strip so detections toggle
        for (int f = 0; f < 12; f++) begin
            int fav;
            int n;
            fav = int'($urandom_range(0, 1));
            n = int'($urandom_range(150, 420));
            for (int p = 0; p < n; p++) begin
                int x;
                x = ($urandom_range(0, 9) < 7) ? fav * 160 + int'($urandom_range(0, 159))
                                               : int'($urandom_range(0, 700));
                cyc($urandom_range(0, 7) != 0, x, int'($urandom_range(0, 520)),
                    $urandom_range(0, 3) != 0, 1'b0, 1'b0);
            end
            close_frame($urandom_range(0, 1) == 1, int'($urandom_range(0, 639)),
                        $sformatf("rnd%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
